// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: byte-link framing constants and state encoding shared by the TX dump and RX decoder
package uart_frame_pkg;
  localparam logic [7:0] START_BYTE        = 8'hF5;
  localparam logic [7:0] STOP_BYTE         = 8'hFA;
  localparam logic [7:0] READ_OUT_MEM_BYTE = 8'hF6;
  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 12;
  localparam int ADDR_SPLIT_W = 5;
  localparam int DATA_SPLIT_W = 6;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, TRAILER, DONE} state_t;
endpackage

// File: rtl/frame_byte_mux.sv
// frame_byte_mux: picks one byte of a START/addr/word/STOP frame by byte index
module frame_byte_mux
  import uart_frame_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        idx,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        tx_data
);
  // payload bytes are zero-extended split fields, so they stay below 0x40 and never alias a marker
  always_comb begin
    case (idx)
      3'd0:    tx_data = START_BYTE;
      3'd1:    tx_data = 8'(addr[ADDR_W-1:ADDR_SPLIT_W]);
      3'd2:    tx_data = 8'(addr[ADDR_SPLIT_W-1:0]);
      3'd3:    tx_data = 8'(word[DATA_W-1:DATA_SPLIT_W]);
      3'd4:    tx_data = 8'(word[DATA_SPLIT_W-1:0]);
      default: tx_data = STOP_BYTE;
    endcase
  end
endmodule

// File: rtl/mem_dump_framer.sv
// mem_dump_framer: walks memory 0..DEPTH-1 and streams one framed word per address, then a trailer byte
module mem_dump_framer
  import uart_frame_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] word;
  logic [2:0]        idx;
  logic [7:0]        frame_byte;

  frame_byte_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .idx     (idx),
    .addr    (addr),
    .word    (word),
    .tx_data (frame_byte)
  );

  assign mem_addr = addr;
  assign tx_data  = !tx_valid ? 8'h00 : (state == TRAILER) ? READ_OUT_MEM_BYTE : frame_byte;

  // dump sequencer; strobes are registered and set on the transition into the state that owns them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      word      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      tx_valid  <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr      <= '0;
          busy      <= 1'b1;
          mem_rd_en <= 1'b1;
          state     <= READ;
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          word     <= mem_rdata;
          idx      <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: if (tx_ready) begin
          if (idx != 3'd5) idx <= idx + 3'd1;
          else if (addr == LAST_ADDR) state <= TRAILER;
          else begin
            addr      <= addr + 1'b1;
            tx_valid  <= 1'b0;
            mem_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        TRAILER: if (tx_ready) begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dump_framer.sv
// tb_mem_dump_framer: scoreboard bench comparing framed dump bytes against a memory-walk reference
module tb_mem_dump_framer;
  localparam int AW = 10, DW = 12, D = 1024;
  logic clk = 0, rst_n = 0;
  logic start_a = 0, start_b = 0, tx_ready = 1, ready_b = 1;
  logic busy_a, done_a, rd_a, valid_a, busy_b, done_b, rd_b, valid_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] rdata_a = '0, rdata_b = '0;
  logic [7:0] data_a, data_b;
  logic [DW-1:0] mem [D];
  logic [7:0] exp_a[$], exp_b[$], got_a[$], got_prev[$];
  int errors = 0, checks = 0;
  int rd_a_cnt = 0, done_a_cnt = 0, done_b_cnt = 0, bytes_a = 0;
  bit stall = 0, hold_a = 0, f6_a = 0, f6_b = 0;
  logic [7:0] held_a, e_a, e_b;

  mem_dump_framer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .tx_data(data_a), .tx_valid(valid_a), .tx_ready(tx_ready));

  mem_dump_framer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b));

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_a) rdata_a <= mem[addr_a];
    if (rd_b) rdata_b <= mem[addr_b];
  end

  initial forever begin
    @(posedge clk);
    #1 tx_ready = stall ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference: every address in order, each as START, addr hi/lo, word hi/lo, STOP, then one trailer
  task automatic push_dump(int depth, bit to_b);
    logic [7:0] q[$];
    for (int a = 0; a < depth; a++) begin
      int w = int'(mem[a]);
      q.push_back(8'hF5); q.push_back(8'(a / 32)); q.push_back(8'(a % 32));
      q.push_back(8'(w / 64)); q.push_back(8'(w % 64)); q.push_back(8'hFA);
    end
    q.push_back(8'hF6);
    foreach (q[i]) if (to_b) exp_b.push_back(q[i]); else exp_a.push_back(q[i]);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_a = 0;
      f6_a = 0;
    end else begin
      if (rd_a) rd_a_cnt++;
      if (done_a) done_a_cnt++;
      if (done_a || f6_a) check("done_after_trailer", int'(done_a), int'(f6_a));
      f6_a = 0;
      if (hold_a) begin
        check("stall_valid_hold", int'(valid_a), 1);
        check("stall_data_hold", data_a, held_a);
      end
      if (valid_a && tx_ready) begin
        bytes_a++;
        got_a.push_back(data_a);
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte actual=%0h required=none at %0t", data_a, $time);
        end else begin
          e_a = exp_a.pop_front();
          check("byte_a", data_a, e_a);
          if (e_a < 8'h40) check("payload_range", int'(data_a < 8'h40), 1);
        end
        f6_a = (data_a == 8'hF6);
      end
      hold_a = valid_a && !tx_ready;
      held_a = data_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) f6_b = 0;
    else begin
      if (done_b) done_b_cnt++;
      if (done_b || f6_b) check("done_b_after_trailer", int'(done_b), int'(f6_b));
      f6_b = 0;
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte_b actual=%0h required=none at %0t", data_b, $time);
        end else begin
          e_b = exp_b.pop_front();
          check("byte_b", data_b, e_b);
        end
        f6_b = (data_b == 8'hF6);
      end
    end
  end

  task automatic pulse_a();
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
  endtask

  task automatic wait_done_a(int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) break;
    end
    check("done_a_within_budget", int'(i < budget), 1);
  endtask

  task automatic run_a(bit stalled);
    int c0, i;
    stall = stalled;
    got_a.delete();
    rd_a_cnt = 0;
    c0 = done_a_cnt;
    push_dump(D, 0);
    pulse_a();
    for (i = 0; i < 200 && !valid_a; i++) @(negedge clk);
    repeat (15) @(negedge clk);
    start_a = 1;
    @(negedge clk) start_a = 0;
    wait_done_a(40000);
    start_a = 1;
    @(negedge clk) start_a = 0;
    repeat (20) @(negedge clk);
    check("busy_idle_after_ignored_start", int'(busy_a), 0);
    check("single_done", done_a_cnt - c0, 1);
    check("scoreboard_drained", exp_a.size(), 0);
    check("mem_rd_en_count", rd_a_cnt, D);
    check("total_bytes", got_a.size(), 6 * D + 1);
    stall = 0;
  endtask

  initial begin
    int i, diff;
    #2;
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_rd_en", int'(rd_a), 0);
    check("rst_tx_data", data_a, 0);
    check("rst_addr", addr_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    mem[0] = 12'hABC;
    push_dump(1, 1);
    start_b = 1;
    @(posedge clk);
    @(negedge clk) start_b = 0;
    check("b_read_strobe", int'(rd_b), 1);
    check("b_read_addr", addr_b, 0);
    check("b_busy", int'(busy_b), 1);
    check("b_valid_n1", int'(valid_b), 0);
    @(negedge clk) check("b_valid_n2", int'(valid_b), 0);
    @(negedge clk) check("b_valid_n3", int'(valid_b), 1);
    check("b_first_byte", data_b, 8'hF5);
    repeat (20) @(negedge clk);
    check("b_done_count", done_b_cnt, 1);
    check("b_drained", exp_b.size(), 0);

    foreach (mem[k]) mem[k] = DW'($urandom);
    mem[10'h2A5] = 12'h041;
    mem[10'h3FF] = 12'hFFF;

    run_a(0);
    check("f2a5_b1", got_a[10'h2A5 * 6 + 1], 8'h15);
    check("f2a5_b2", got_a[10'h2A5 * 6 + 2], 8'h05);
    check("f2a5_b3", got_a[10'h2A5 * 6 + 3], 8'h01);
    check("f2a5_b4", got_a[10'h2A5 * 6 + 4], 8'h01);
    check("last_addr_hi", got_a[6 * D - 5], 8'h1F);
    check("last_addr_lo", got_a[6 * D - 4], 8'h1F);
    check("last_word_hi", got_a[6 * D - 3], 8'h3F);
    check("last_word_lo", got_a[6 * D - 2], 8'h3F);
    check("last_stop", got_a[6 * D - 1], 8'hFA);
    check("trailer", got_a[6 * D], 8'hF6);
    got_prev = got_a;

    run_a(1);
    diff = (got_a.size() != got_prev.size()) ? 1 : 0;
    for (i = 0; i < got_a.size() && i < got_prev.size(); i++) if (got_a[i] != got_prev[i]) diff++;
    check("stall_sequence_matches_nostall", diff, 0);

    push_dump(D, 0);
    bytes_a = 0;
    pulse_a();
    for (i = 0; i < 2000 && bytes_a < 33; i++) @(negedge clk);
    check("reached_word5", int'(bytes_a >= 33), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", int'(valid_a), 0);
    check("async_rst_busy", int'(busy_a), 0);
    check("async_rst_rd_en", int'(rd_a), 0);
    exp_a.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1;
    got_a.delete();
    push_dump(D, 0);
    pulse_a();
    wait_done_a(40000);
    repeat (3) @(negedge clk);
    check("restart_drained", exp_a.size(), 0);
    check("restart_first_f5", got_a.size() > 0 ? got_a[0] : -1, 8'hF5);
    check("restart_addr_hi0", got_a.size() > 2 ? got_a[1] : -1, 0);
    check("restart_addr_lo0", got_a.size() > 2 ? got_a[2] : -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
